// File: rtl/ysyx_23060072_imem_responder_pkg.sv
// Shared constants for the instruction-fetch responder: FSM encodings, default
// store base address, the NOP used by the IF stage on a fault, and address checks.
package ysyx_23060072_imem_responder_pkg;

   typedef enum logic [1:0] {
      IMEM_IDLE = 2'd0,
      IMEM_WAIT = 2'd1,
      IMEM_RESP = 2'd2
   } imem_state_e;

   localparam logic [31:0] IMEM_BASE_ADDR = 32'h8000_0000;
   localparam logic [31:0] IMEM_NOP       = 32'h0000_0013;

   // An address below base wraps to a huge offset and therefore fails the span compare.
   function automatic logic imem_addr_ok(input logic [31:0] addr, input logic [31:0] base,
                                         input logic [31:0] span);
      logic [31:0] off;
      off = addr - base;
      return (addr[1:0] == 2'b00) && (off < span);
   endfunction

endpackage

// File: rtl/ysyx_23060072_imem_responder_if.sv
// Fetch request/response bundle between the IF stage (master) and the responder (slave).
// Signal suffixes are from the responder's point of view.
interface ysyx_23060072_imem_responder_if;

   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] req_addr_i;
   logic        flush_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_data_o;
   logic        rsp_err_o;

   modport master (
      output req_valid_i, req_addr_i, flush_i, rsp_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
   );

   modport slave (
      input  req_valid_i, req_addr_i, flush_i, rsp_ready_i,
      output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
   );

endinterface

// File: rtl/ysyx_23060072_imem_array.sv
// DEPTH x 32 instruction store: one synchronous write port, one combinational read port.
// Contents are not reset.
module ysyx_23060072_imem_array #(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned AW    = 10
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ysyx_23060072_imem_responder.sv
// Instruction-fetch responder: fixed-latency valid/ready fetch out of a local store.
// Define YSYX_23060072_IMEM_ERR_EN to flag misaligned/out-of-range fetches via rsp_err_o.
module ysyx_23060072_imem_responder
   import ysyx_23060072_imem_responder_pkg::*;
#(
   parameter int unsigned LATENCY   = 2,
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned AW        = 10,
   parameter logic [31:0] BASE_ADDR = IMEM_BASE_ADDR
) (
   input  logic                            clk,
   input  logic                            rst,
   ysyx_23060072_imem_responder_if.slave   bus,
   input  logic                            wr_en_i,
   input  logic [31:0]                     wr_addr_i,
   input  logic [31:0]                     wr_data_i,
   output logic                            busy_o
);

   localparam logic [31:0] Span    = 32'(DEPTH) << 2;
   localparam logic [3:0]  LatLoad = 4'(LATENCY - 1);

   imem_state_e state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic        err_q, err_d;

   logic [31:0] rd_addr, rd_off, wr_off, rd_word, fetch_data;
   logic [AW-1:0] rd_idx, wr_idx;
   logic        wr_ok, fetch_err, req_ready, rsp_valid;
   logic        unused_off;

   // In IDLE the read port looks at the incoming pc so LATENCY==1 can enter RESP directly.
   assign rd_addr = (state_q == IMEM_IDLE) ? bus.req_addr_i : addr_q;
   assign rd_off  = rd_addr - BASE_ADDR;
   assign rd_idx  = rd_off[AW+1:2];
   assign wr_off  = wr_addr_i - BASE_ADDR;
   assign wr_idx  = wr_off[AW+1:2];
   assign wr_ok   = imem_addr_ok(wr_addr_i, BASE_ADDR, Span);
   assign unused_off = ^{rd_off[31:AW+2], rd_off[1:0], wr_off[31:AW+2], wr_off[1:0]};

   ysyx_23060072_imem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk_i   (clk),
      .we_i    (wr_en_i && wr_ok),
      .waddr_i (wr_idx),
      .wdata_i (wr_data_i),
      .raddr_i (rd_idx),
      .rdata_o (rd_word)
   );

`ifdef YSYX_23060072_IMEM_ERR_EN
   assign fetch_err  = !imem_addr_ok(rd_addr, BASE_ADDR, Span);
   assign fetch_data = fetch_err ? 32'h0 : rd_word;
`else
   assign fetch_err  = 1'b0;
   assign fetch_data = rd_word;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      data_d    = data_q;
      err_d     = err_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      unique case (state_q)
         IMEM_IDLE: begin
            req_ready = !bus.flush_i;
            if (bus.req_valid_i && req_ready) begin
               addr_d = bus.req_addr_i;
               cnt_d  = LatLoad;
               if (LATENCY == 1) begin
                  state_d = IMEM_RESP;
                  data_d  = fetch_data;
                  err_d   = fetch_err;
               end else begin
                  state_d = IMEM_WAIT;
               end
            end
         end
         IMEM_WAIT: begin
            if (bus.flush_i) begin
               state_d = IMEM_IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = IMEM_RESP;
               data_d  = fetch_data;
               err_d   = fetch_err;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         IMEM_RESP: begin
            rsp_valid = 1'b1;
            if (bus.flush_i || bus.rsp_ready_i) begin
               state_d = IMEM_IDLE;
            end
         end
         default: state_d = IMEM_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IMEM_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 32'h0;
         data_q  <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   assign bus.req_ready_o = req_ready;
   assign bus.rsp_valid_o = rsp_valid;
   assign bus.rsp_data_o  = data_q;
   assign bus.rsp_err_o   = err_q;
   assign busy_o          = (state_q != IMEM_IDLE);

endmodule
